// File: rtl/invmat_loader.sv
// -----------------------------------------------------------------------------
// invmat_loader
//
// Upstream feeder for invmat. Collects a row-major, element-serial stream of
// fixed-point matrix entries (valid/ready handshake), assembles one complete
// MAT_SIZE x MAT_SIZE matrix into a flat bus and offers it to invmat through
// its ready/mat_vld/mat_in handshake. Frame boundaries are checked against
// s_last; a badly framed matrix is discarded and flagged on frame_err.
//
// Optional feature (compile-time macro):
//   INVMAT_LOADER_DBUF_EN  defined   -> two banks, ping-pong write/read pointers,
//                                       so the next matrix streams in while the
//                                       previous one waits on invmat.
//                          undefined -> single bank, both pointers tied to 0.
//
// Ports:
//   clk        in   1                 sole clock, rising edge
//   reset      in   1                 asynchronous, active-high reset
//   s_vld      in   1                 stream element valid
//   s_rdy      out  1                 loader can accept an element
//   s_dat      in   MAT_DWIDTH        stream element, row-major order
//   s_last     in   1                 marks element N*N-1 of a matrix
//   ready      in   1                 invmat can accept a matrix
//   mat_vld    out  1                 mat_in holds a complete matrix
//   mat_in     out  MAT_DWIDTH*N*N    element (r,c) at offset MAT_DWIDTH*(N*r+c)
//   frame_err  out  1                 one-cycle pulse per discarded frame
//   busy       out  1                 data buffered or matrix pending
// -----------------------------------------------------------------------------
module invmat_loader #(
    parameter int MAT_SIZE   = 5,
    parameter int MAT_DWIDTH = 46
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     s_vld,
    output logic                                     s_rdy,
    input  logic [MAT_DWIDTH-1:0]                    s_dat,
    input  logic                                     s_last,
    input  logic                                     ready,
    output logic                                     mat_vld,
    output logic [MAT_DWIDTH*MAT_SIZE*MAT_SIZE-1:0]  mat_in,
    output logic                                     frame_err,
    output logic                                     busy
);

    localparam int NN = MAT_SIZE * MAT_SIZE;
    localparam int IW = $clog2(NN);
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1'b1);

`ifdef INVMAT_LOADER_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    // Storage and state
    logic [MAT_DWIDTH-1:0] bank_q [NB][NN];
    logic [NB-1:0]         full_q;
    logic [NB-1:0]         full_d;
    logic [IW-1:0]         widx_q;
    logic [IW-1:0]         widx_d;
    logic                  frame_err_q;
    logic                  frame_err_d;

    // Bank pointers as seen by the datapath (flops or constant 0)
    logic                  wbank_s;
    logic                  rbank_s;

    // Handshake and framing decodes
    logic                  accept_s;
    logic                  xfer_s;
    logic                  idx_last_s;
    logic                  frame_ok_s;
    logic                  frame_bad_s;

    // Handshake decodes and frame classification of the element being accepted.
    always_comb begin
        accept_s    = s_vld & s_rdy;
        xfer_s      = mat_vld & ready;
        idx_last_s  = (widx_q == LAST_IDX);
        // A frame is good only when s_last coincides exactly with the final slot;
        // any disagreement between the two is a framing error.
        frame_ok_s  = accept_s & idx_last_s & s_last;
        frame_bad_s = accept_s & (idx_last_s ^ s_last);
    end

    // Write index: advance per accept, return to slot 0 on any frame end (good or bad).
    always_comb begin
        widx_d = widx_q;
        if (accept_s) begin
            if (idx_last_s || s_last) begin
                widx_d = '0;
            end else begin
                widx_d = widx_q + IDX_ONE;
            end
        end else begin
            widx_d = widx_q;
        end
    end

    // Full flags: drain clears the read bank, a good frame fills the write bank.
    // Both can happen on the same edge only for different banks, because an
    // accept needs the write bank empty and a transfer needs the read bank full.
    always_comb begin
        full_d = full_q;
        if (xfer_s) begin
            full_d[rbank_s] = 1'b0;
        end else begin
            full_d[rbank_s] = full_q[rbank_s];
        end
        if (frame_ok_s) begin
            full_d[wbank_s] = 1'b1;
        end else begin
            full_d[wbank_s] = full_d[wbank_s];
        end
    end

    // Discard pulse for a badly framed matrix, raised in the following cycle.
    always_comb begin
        if (frame_bad_s) begin
            frame_err_d = 1'b1;
        end else begin
            frame_err_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q      <= '0;
            widx_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            widx_q      <= widx_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Element storage; cleared on reset so no stale matrix can ever surface.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                for (int i = 0; i < NN; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else if (accept_s) begin
            bank_q[wbank_s][widx_q] <= s_dat;
        end else begin
            bank_q[wbank_s][widx_q] <= bank_q[wbank_s][widx_q];
        end
    end

`ifdef INVMAT_LOADER_DBUF_EN
    logic wbank_q;
    logic wbank_d;
    logic rbank_q;
    logic rbank_d;

    // Ping-pong pointers: write side flips on a good frame, read side on a transfer.
    always_comb begin
        if (frame_ok_s) begin
            wbank_d = ~wbank_q;
        end else begin
            wbank_d = wbank_q;
        end
        if (xfer_s) begin
            rbank_d = ~rbank_q;
        end else begin
            rbank_d = rbank_q;
        end
    end

    // Bank pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
        end else begin
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
        end
    end

    assign wbank_s = wbank_q;
    assign rbank_s = rbank_q;
`else
    assign wbank_s = 1'b0;
    assign rbank_s = 1'b0;
`endif

    // Flatten the read bank onto the output bus, element i = N*r + c.
    always_comb begin
        mat_in = '0;
        for (int i = 0; i < NN; i++) begin
            mat_in[MAT_DWIDTH*i +: MAT_DWIDTH] = bank_q[rbank_s][i];
        end
    end

    // s_rdy is held low while reset is applied even though the flags are already clear.
    assign s_rdy     = ~reset & ~full_q[wbank_s];
    assign mat_vld   = full_q[rbank_s];
    assign frame_err = frame_err_q;
    assign busy      = mat_vld | (widx_q != '0) | (|full_q);

endmodule
